sample_depacketizer: RTL and testbench

SAMPLE_DEPACKETIZER -- requirements
Module: sample_depacketizer

---
 rtl/sample_depacketizer.sv | 178 +++++++++++++++++
 tb/tb_sample_depacketizer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_depacketizer.sv
// ============================================================================
// sample_depacketizer
// Rebuilds multi-channel samples from a tagged 28-bit link word stream
// (IDLE / SYNC / HEADER / DATA) and publishes them atomically on completion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_depacketizer #(
    parameter int CHANNEL   = 16,
    parameter int DATA_BITS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [27:0]                    rx_data,
    output logic [DATA_BITS*CHANNEL-1:0]   data_out,
    output logic                           sample_valid,
    output logic                           begin_of_sample,
    output logic                           running,
    output logic                           proto_error,
    output logic [31:0]                    sample_count
);

    localparam logic [3:0] TAG_IDLE   = 4'd0;
    localparam logic [3:0] TAG_SYNC   = 4'd1;
    localparam logic [3:0] TAG_HEADER = 4'd2;
    localparam logic [3:0] TAG_DATA   = 4'd3;

    typedef enum logic [1:0] {
        S_HUNT     = 2'd0,
        S_WAIT_HDR = 2'd1,
        S_DATA     = 2'd2
    } state_t;

    state_t                         state, state_next;
    logic [DATA_BITS*CHANNEL-1:0]   shadow;
    logic [DATA_BITS*CHANNEL-1:0]   shadow_wr;
    logic [CHANNEL-1:0]             pending;
    logic [CHANNEL-1:0]             pending_clr;
    logic [3:0]                     low_idx;

    logic [3:0]                     tag;
    logic [3:0]                     idx;
    logic [CHANNEL-1:0]             hdr_bits;
    logic [DATA_BITS-1:0]           value;

    logic                           do_sync;
    logic                           do_err;
    logic                           do_hdr;
    logic                           do_write;
    logic                           do_complete;
    logic                           unused_rx;

    assign tag       = rx_data[27:24];
    assign idx       = rx_data[19:16];
    assign hdr_bits  = rx_data[CHANNEL-1:0];
    assign value     = rx_data[DATA_BITS-1:0];
    assign running   = (state != S_HUNT);
    // Many link-word bits are don't-care depending on tag and parameters.
    assign unused_rx = ^rx_data;

    // Lowest still-pending channel: the only index a DATA word may carry.
    always_comb begin
        low_idx = '0;
        for (int i = CHANNEL - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Candidate shadow/pending contents if the current DATA word is accepted.
    always_comb begin
        pending_clr = pending;
        shadow_wr   = shadow;
        for (int k = 0; k < CHANNEL; k++) begin
            if (4'(k) == low_idx) begin
                pending_clr[k]                     = 1'b0;
                shadow_wr[k*DATA_BITS +: DATA_BITS] = value;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Tag decode and next-state selection; SYNC overrides every state.
    always_comb begin
        state_next  = state;
        do_sync     = 1'b0;
        do_err      = 1'b0;
        do_hdr      = 1'b0;
        do_write    = 1'b0;
        do_complete = 1'b0;
        if (tag == TAG_SYNC) begin
            do_sync    = 1'b1;
            state_next = S_WAIT_HDR;
        end else if (tag != TAG_IDLE) begin
            case (state)
                S_WAIT_HDR: begin
                    if (tag == TAG_HEADER) begin
                        if (hdr_bits == '0) begin
                            do_complete = 1'b1;
                        end else begin
                            do_hdr     = 1'b1;
                            state_next = S_DATA;
                        end
                    end else begin
                        do_err = 1'b1;
                    end
                end
                S_DATA: begin
                    if (tag == TAG_DATA && idx == low_idx) begin
                        do_write = 1'b1;
                        if (pending_clr == '0) begin
                            do_complete = 1'b1;
                            state_next  = S_WAIT_HDR;
                        end
                    end else begin
                        do_err = 1'b1;
                    end
                end
                default: ;  // HUNT waits silently for SYNC
            endcase
            if (do_err) begin
                state_next = S_HUNT;
            end
        end
    end

    // Sample datapath and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out        <= '0;
            shadow          <= '0;
            pending         <= '0;
            sample_count    <= '0;
            sample_valid    <= 1'b0;
            begin_of_sample <= 1'b0;
            proto_error     <= 1'b0;
        end else begin
            sample_valid    <= do_complete;
            begin_of_sample <= do_sync;
            proto_error     <= do_err | (do_sync && state == S_DATA);
            if (do_sync) begin
                shadow       <= '0;
                data_out     <= '0;
                pending      <= '0;
                sample_count <= '0;
            end else if (do_err) begin
                // Drop the partial packet; committed data stays untouched.
                shadow  <= data_out;
                pending <= '0;
            end else begin
                if (do_hdr) begin
                    pending <= hdr_bits;
                end
                if (do_write) begin
                    shadow  <= shadow_wr;
                    pending <= pending_clr;
                end
                if (do_complete) begin
                    data_out     <= do_write ? shadow_wr : shadow;
                    sample_count <= sample_count + 32'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sample_depacketizer.sv
// ============================================================================
// tb_sample_depacketizer
// Directed self-checking bench for sample_depacketizer (16 ch x 16 bit).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sample_depacketizer;

    logic         clk;
    logic         rst_n;
    logic [27:0]  rx_data;
    logic [255:0] data_out;
    logic         sample_valid;
    logic         begin_of_sample;
    logic         running;
    logic         proto_error;
    logic [31:0]  sample_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] exp1, exp2, exp3, exp4;

    sample_depacketizer #(.CHANNEL(16), .DATA_BITS(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .data_out        (data_out),
        .sample_valid    (sample_valid),
        .begin_of_sample (begin_of_sample),
        .running         (running),
        .proto_error     (proto_error),
        .sample_count    (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] w_sync();
        return {4'h1, 24'h0};
    endfunction

    function automatic logic [27:0] w_hdr(input logic [15:0] bits);
        return {4'h2, 8'h00, bits};
    endfunction

    function automatic logic [27:0] w_dat(input logic [3:0] i, input logic [15:0] v);
        return {4'h3, 4'h0, i, v};
    endfunction

    // Present one word for one rising edge; outputs reflect it on return.
    task automatic send(input logic [27:0] w);
        rx_data = w;
        @(negedge clk);
        rx_data = 28'h0;
    endtask

    initial begin
        exp1 = '0; exp1[15:0] = 16'h1234; exp1[47:32] = 16'hBEEF;
        exp2 = exp1; exp2[31:16] = 16'h00AA;
        exp3 = exp2; exp3[255:240] = 16'h7777;
        exp4 = '0; exp4[15:0] = 16'h4242;

        rst_n   = 1'b0;
        rx_data = 28'h0;
        repeat (2) @(negedge clk);
        check("rst_data",  data_out, '0);
        check("rst_valid", sample_valid, 0);
        check("rst_bos",   begin_of_sample, 0);
        check("rst_run",   running, 0);
        check("rst_err",   proto_error, 0);
        check("rst_cnt",   sample_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // HUNT ignores everything but SYNC, silently
        send(w_hdr(16'h0005));
        check("hunt_hdr_err", proto_error, 0);
        send(w_dat(4'd0, 16'h0001));
        check("hunt_dat_err", proto_error, 0);
        send({4'hB, 24'h0});
        check("hunt_ill_err", proto_error, 0);
        check("hunt_run", running, 0);

        // Basic packet
        send(w_sync());
        check("sync_bos", begin_of_sample, 1);
        check("sync_run", running, 1);
        send(w_hdr(16'h0005));
        check("hdr_bos_off", begin_of_sample, 0);
        send(w_dat(4'd0, 16'h1234));
        check("partial_hidden", data_out, '0);
        check("partial_valid", sample_valid, 0);
        send(w_dat(4'd2, 16'hBEEF));
        check("pkt1_valid", sample_valid, 1);
        check("pkt1_data",  data_out, exp1);
        check("pkt1_cnt",   sample_count, 1);
        send(28'h0);
        check("pkt1_pulse", sample_valid, 0);

        // Empty header repeats previous sample
        send(w_hdr(16'h0000));
        check("empty_valid", sample_valid, 1);
        check("empty_data",  data_out, exp1);
        check("empty_cnt",   sample_count, 2);

        // Back-to-back packets, including the top channel
        send(w_hdr(16'h0002));
        send(w_dat(4'd1, 16'h00AA));
        check("b2b1_data", data_out, exp2);
        send(w_hdr(16'h8000));
        check("b2b_gap_valid", sample_valid, 0);
        send(w_dat(4'd15, 16'h7777));
        check("b2b2_valid", sample_valid, 1);
        check("b2b2_data",  data_out, exp3);
        check("b2b2_cnt",   sample_count, 4);

        // Wrong index: error, back to HUNT, committed state held
        send(w_hdr(16'h0003));
        send(w_dat(4'd1, 16'h0055));
        check("idx_err",  proto_error, 1);
        check("idx_run",  running, 0);
        check("idx_data", data_out, exp3);
        check("idx_cnt",  sample_count, 4);
        send(w_hdr(16'h0000));
        check("hunt_ign_valid", sample_valid, 0);
        check("hunt_ign_cnt",   sample_count, 4);

        // IDLE interleaved packet
        send(w_sync());
        check("resync_data", data_out, '0);
        check("resync_cnt",  sample_count, 0);
        send(28'h0);
        send(w_hdr(16'h0005));
        send(28'h0);
        send(28'h0);
        send(w_dat(4'd0, 16'h1234));
        send(28'h0);
        check("idle_mid_valid", sample_valid, 0);
        send(w_dat(4'd2, 16'hBEEF));
        check("idle_valid", sample_valid, 1);
        check("idle_data",  data_out, exp1);
        check("idle_cnt",   sample_count, 1);

        // SYNC in the middle of DATA
        send(w_hdr(16'h0005));
        send(w_dat(4'd0, 16'h0001));
        send(w_sync());
        check("midsync_err",  proto_error, 1);
        check("midsync_bos",  begin_of_sample, 1);
        check("midsync_data", data_out, '0);
        check("midsync_cnt",  sample_count, 0);
        check("midsync_run",  running, 1);
        send(w_hdr(16'h0000));
        check("midsync_wait", sample_count, 1);

        // DATA while waiting for a header
        send(w_dat(4'd0, 16'h0009));
        check("dat_wait_err", proto_error, 1);
        check("dat_wait_run", running, 0);

        // Illegal tag outside HUNT
        send(w_sync());
        send({4'hA, 24'h0});
        check("ill_err", proto_error, 1);

        // HEADER inside DATA
        send(w_sync());
        send(w_hdr(16'h0001));
        send(w_hdr(16'h0001));
        check("hdr_in_data_err", proto_error, 1);

        // Header bits above CHANNEL-1 are ignored (bits 23:16 set here)
        send(w_sync());
        send({4'h2, 8'hFF, 16'h0001});
        send(w_dat(4'd0, 16'h4242));
        check("hi_bits_valid", sample_valid, 1);
        check("hi_bits_data",  data_out, exp4);

        // Asynchronous reset mid-packet
        send(w_hdr(16'h0003));
        send(w_dat(4'd0, 16'h0011));
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", data_out, '0);
        check("arst_cnt",  sample_count, 0);
        check("arst_run",  running, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(w_dat(4'd1, 16'h0022));
        check("post_rst_err",   proto_error, 0);
        check("post_rst_valid", sample_valid, 0);
        check("post_rst_data",  data_out, '0);
        check("post_rst_run",   running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
